hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
Hazard and sequencing controller for the 5-stage pipelined ARM datapath. It drives the datapath's StallF, StallD, FlushD, FlushE, ForwardAE and ForwardBE, plus extra stall and flush controls for Execute, Memory and Writeback. It resolves three things: register forwarding, load-use stalls, and control hazards from PC writes and branches. It also runs a data-memory wait-state FSM that freezes the pipeline until dmem acknowledges, with a timeout.

Parameters:
MEM_TIMEOUT, 16, maximum wait cycles for a memory access before forced release; must be at least 1.
CNT_W, 5, width of the wait counter; must satisfy 2^CNT_W > MEM_TIMEOUT.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous reset, active-low (reset==0 resets on the clk edge)
RA1D, RA2D  input  4  Decode-stage source register numbers
RA1E, RA2E  input  4  Execute-stage source register numbers
WA3E, WA3M, WA3W  input  4  destination register numbers in Execute, Memory and Writeback
MemtoRegE  input  1  instruction in Execute is a load
RegWriteM, RegWriteW  input  1  register writes pending in Memory and Writeback
PCWrPendingF  input  1  PCSrcD | PCSrcE | PCSrcM
PCSrcW  input  1  Writeback is writing the PC
BranchTakenE  input  1  branch resolved taken in Execute
MemAccessM  input  1  Memory stage holds a load or store
MemReadyM  input  1  dmem acknowledges the current access this cycle
ForwardAE, ForwardBE  output  2  00 = register file, 01 = ResultW, 10 = ALUOutM
StallF, StallD, StallE, StallM  output  1  hold the corresponding pipeline register
FlushD, FlushE, FlushW  output  1  insert a bubble into the corresponding pipeline register
MemErr  output  1  sticky flag: a memory access timed out

Behaviour:
- Forwarding (combinational):
  - ForwardAE = 10 if RegWriteM and WA3M==RA1E.
  - Otherwise ForwardAE = 01 if RegWriteW and WA3W==RA1E.
  - Otherwise ForwardAE = 00.
  - The Memory stage has priority over Writeback.
  - ForwardBE uses the same rules with RA2E.
- Load-use: ldrStall = MemtoRegE & (WA3E==RA1D | WA3E==RA2D).
- FSM states: RUN, WAIT. Both the state register and the counter are synchronous.
- RUN to WAIT: when MemAccessM & ~MemReadyM. The counter loads 1.
- WAIT, leaving to RUN:
  - If MemReadyM: return to RUN, counter clears.
  - Else if counter==MEM_TIMEOUT: return to RUN, set MemErr, counter clears.
- WAIT, staying: otherwise increment the counter, saturating at MEM_TIMEOUT.
- freeze = (RUN & MemAccessM & ~MemReadyM) | (WAIT & ~MemReadyM & counter!=MEM_TIMEOUT). freeze is a combinational output path.
- When freeze = 1:
  - StallF, StallD, StallE, StallM = 1.
  - FlushW = 1, so the Writeback stage does not repeat its write.
  - FlushD = FlushE = 0. Control and branch flushes are deferred: the frozen stages keep their instructions and the flush fires in the release cycle.
- When freeze = 0:
  - StallF = ldrStall | PCWrPendingF
  - StallD = ldrStall
  - FlushD = PCWrPendingF | PCSrcW | BranchTakenE
  - FlushE = ldrStall | BranchTakenE
  - StallE = StallM = FlushW = 0
- Simultaneous load-use and branch-taken: FlushE = 1 and StallD = 1. The branch wins because FlushD is also asserted.
- Release cycle (MemReadyM=1 in WAIT): outputs equal the freeze=0 equations in that same cycle, so latency from acknowledge to pipeline advance is 0 cycles.
- Reset (reset==0 at the clk edge): state goes to RUN, counter to 0, MemErr to 0.
  - A reset during WAIT abandons the access.
  - All outputs are combinational functions of state and inputs. After reset, with all inputs at 0, every output is 0.
- MemErr is cleared only by reset.

Optional Feature:
- Macro HAZARD_PERF_EN. When defined, the block adds three 32-bit outputs, each reset to 0 and wrapping modulo 2^32:
  - PerfStallCyc: increments on each cycle with StallF=1.
  - PerfFlushCyc: increments on each cycle with FlushE=1.
  - PerfMemWaitCyc: increments on each cycle with freeze=1.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Package hazard_pkg holds:
  - the forward-select constants FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10;
  - the FSM state encoding ST_RUN, ST_WAIT;
  - the MEM_TIMEOUT default.
- One sub-module, mem_wait_fsm, contains the state, the counter and MemErr, and outputs freeze. hazard_ctrl instantiates it and adds the combinational forwarding and stall/flush logic.

Test Plan:
- Forwarding priority: RegWriteM=1, WA3M=3; RegWriteW=1, WA3W=3; RA1E=3, RA2E=3 -> ForwardAE=ForwardBE=10. With RegWriteM=0 -> both 01.
- Load-use: MemtoRegE=1, WA3E=2, RA2D=2 -> StallF=StallD=FlushE=1 for exactly 1 cycle, FlushD=0.
- Memory wait: MemAccessM=1, MemReadyM=0 for 3 cycles, then 1 -> all stalls and FlushW=1 for 3 cycles, all 0 in the 4th cycle, MemErr=0.
- Timeout: MemReadyM held at 0 with MEM_TIMEOUT=16 -> freeze for 16 cycles, release on the 17th cycle, MemErr=1 and sticky until reset==0.
- Branch during freeze: BranchTakenE=1 while frozen -> FlushD=FlushE=0. In the release cycle -> FlushD=FlushE=1.
- Reset in WAIT: reset=0 during the 2nd wait cycle -> next cycle state is RUN, counter is 0, all outputs are 0 with idle inputs. Perf counters read 0 when HAZARD_PERF_EN is defined.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared constants for the pipeline hazard controller: forward selects,
// wait-FSM state encoding and the default memory timeout.
package hazard_pkg;

   localparam logic [1:0] FWD_RF = 2'b00;
   localparam logic [1:0] FWD_W  = 2'b01;
   localparam logic [1:0] FWD_M  = 2'b10;

   localparam int MEM_TIMEOUT_DEF = 16;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_WAIT = 1'b1
   } state_t;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Datapath <-> hazard controller signal bundle. Optional perf counters are
// present only when HAZARD_PERF_EN is defined.
interface hazard_ctrl_if
   import hazard_pkg::*;
#(
   parameter int CNT_W = 5
);
   logic [3:0] RA1D, RA2D, RA1E, RA2E;
   logic [3:0] WA3E, WA3M, WA3W;
   logic       MemtoRegE, RegWriteM, RegWriteW;
   logic       PCWrPendingF, PCSrcW, BranchTakenE;
   // Memory handshake: MemAccessM acts as valid, MemReadyM as ready; an access
   // completes in the cycle both are high. Until then the pipeline is frozen.
   logic       MemAccessM, MemReadyM;

   logic [1:0] ForwardAE, ForwardBE;
   logic       StallF, StallD, StallE, StallM;
   logic       FlushD, FlushE, FlushW;
   logic       MemErr;

   state_t           dbg_state;
   logic [CNT_W-1:0] dbg_cnt;
`ifdef HAZARD_PERF_EN
   logic [31:0] PerfStallCyc, PerfFlushCyc, PerfMemWaitCyc;
`endif

   modport master (
      output RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W,
      output MemtoRegE, RegWriteM, RegWriteW,
      output PCWrPendingF, PCSrcW, BranchTakenE, MemAccessM, MemReadyM,
      input  ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
      input  FlushD, FlushE, FlushW, MemErr, dbg_state, dbg_cnt
`ifdef HAZARD_PERF_EN
      , input PerfStallCyc, PerfFlushCyc, PerfMemWaitCyc
`endif
   );

   modport slave (
      input  RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W,
      input  MemtoRegE, RegWriteM, RegWriteW,
      input  PCWrPendingF, PCSrcW, BranchTakenE, MemAccessM, MemReadyM,
      output ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
      output FlushD, FlushE, FlushW, MemErr, dbg_state, dbg_cnt
`ifdef HAZARD_PERF_EN
      , output PerfStallCyc, PerfFlushCyc, PerfMemWaitCyc
`endif
   );

endinterface

// File: rtl/mem_wait_fsm.sv
// Data-memory wait-state FSM: freezes the pipeline until dmem acknowledges,
// releasing with a sticky error flag if the access times out.
module mem_wait_fsm
   import hazard_pkg::*;
#(
   parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
   parameter int CNT_W       = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             mem_access,
   input  logic             mem_ready,
   output logic             freeze,
   output logic             mem_err,
   output state_t           state,
   output logic [CNT_W-1:0] cnt
);
   localparam logic [CNT_W-1:0] TMO = CNT_W'(MEM_TIMEOUT);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             mem_err_q, mem_err_d;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= ST_RUN;
         cnt_q     <= '0;
         mem_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         mem_err_q <= mem_err_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      mem_err_d = mem_err_q;
      freeze    = 1'b0;
      case (state_q)
         ST_RUN: begin
            if (mem_access && !mem_ready) begin
               freeze  = 1'b1;
               state_d = ST_WAIT;
               cnt_d   = CNT_W'(1);
            end
         end
         ST_WAIT: begin
            if (mem_ready) begin
               state_d = ST_RUN;
               cnt_d   = '0;
            end else if (cnt_q == TMO) begin
               // Forced release: the access is abandoned and flagged.
               state_d   = ST_RUN;
               cnt_d     = '0;
               mem_err_d = 1'b1;
            end else begin
               freeze = 1'b1;
               cnt_d  = (cnt_q >= TMO) ? TMO : cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = ST_RUN;
            cnt_d   = '0;
         end
      endcase
   end

   assign mem_err = mem_err_q;
   assign state   = state_q;
   assign cnt     = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage ARM pipeline: forwarding, load-use stall,
// control flushes and memory freeze. HAZARD_PERF_EN adds cycle counters.
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
   parameter int CNT_W       = 5
) (
   input  logic           clk,
   input  logic           reset,
   hazard_ctrl_if.slave   hz
);
   logic freeze;
   logic ldr_stall;

   mem_wait_fsm #(
      .MEM_TIMEOUT (MEM_TIMEOUT),
      .CNT_W       (CNT_W)
   ) u_wait (
      .clk        (clk),
      .reset      (reset),
      .mem_access (hz.MemAccessM),
      .mem_ready  (hz.MemReadyM),
      .freeze     (freeze),
      .mem_err    (hz.MemErr),
      .state      (hz.dbg_state),
      .cnt        (hz.dbg_cnt)
   );

   always_comb begin
      hz.ForwardAE = FWD_RF;
      if (hz.RegWriteM && (hz.WA3M == hz.RA1E))      hz.ForwardAE = FWD_M;
      else if (hz.RegWriteW && (hz.WA3W == hz.RA1E)) hz.ForwardAE = FWD_W;

      hz.ForwardBE = FWD_RF;
      if (hz.RegWriteM && (hz.WA3M == hz.RA2E))      hz.ForwardBE = FWD_M;
      else if (hz.RegWriteW && (hz.WA3W == hz.RA2E)) hz.ForwardBE = FWD_W;
   end

   assign ldr_stall = hz.MemtoRegE && ((hz.WA3E == hz.RA1D) || (hz.WA3E == hz.RA2D));

   // While frozen, control flushes are held back so they land on release.
   always_comb begin
      hz.StallF = 1'b0;
      hz.StallD = 1'b0;
      hz.StallE = 1'b0;
      hz.StallM = 1'b0;
      hz.FlushD = 1'b0;
      hz.FlushE = 1'b0;
      hz.FlushW = 1'b0;
      if (freeze) begin
         hz.StallF = 1'b1;
         hz.StallD = 1'b1;
         hz.StallE = 1'b1;
         hz.StallM = 1'b1;
         hz.FlushW = 1'b1;
      end else begin
         hz.StallF = ldr_stall | hz.PCWrPendingF;
         hz.StallD = ldr_stall;
         hz.FlushD = hz.PCWrPendingF | hz.PCSrcW | hz.BranchTakenE;
         hz.FlushE = ldr_stall | hz.BranchTakenE;
      end
   end

`ifdef HAZARD_PERF_EN
   logic [31:0] perf_stall_q, perf_stall_d;
   logic [31:0] perf_flush_q, perf_flush_d;
   logic [31:0] perf_wait_q,  perf_wait_d;

   always_comb begin
      perf_stall_d = perf_stall_q + {31'd0, hz.StallF};
      perf_flush_d = perf_flush_q + {31'd0, hz.FlushE};
      perf_wait_d  = perf_wait_q  + {31'd0, freeze};
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         perf_stall_q <= '0;
         perf_flush_q <= '0;
         perf_wait_q  <= '0;
      end else begin
         perf_stall_q <= perf_stall_d;
         perf_flush_q <= perf_flush_d;
         perf_wait_q  <= perf_wait_d;
      end
   end

   assign hz.PerfStallCyc   = perf_stall_q;
   assign hz.PerfFlushCyc   = perf_flush_q;
   assign hz.PerfMemWaitCyc = perf_wait_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: expected output vectors are queued per step
// and compared against the DUT mid-cycle.
module tb_hazard_ctrl;
   import hazard_pkg::*;

   logic clk;
   logic reset;
   int   checks;
   int   errors;
   logic [11:0] exp_q[$];

   hazard_ctrl_if #(.CNT_W(5)) hz ();

   hazard_ctrl #(.MEM_TIMEOUT(16), .CNT_W(5)) dut (
      .clk   (clk),
      .reset (reset),
      .hz    (hz.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // {ForwardAE, ForwardBE, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemErr}
   function automatic logic [11:0] ev(logic [1:0] fa, logic [1:0] fb,
                                      logic sf, logic sd, logic se, logic sm,
                                      logic fd, logic fe, logic fw, logic me);
      return {fa, fb, sf, sd, se, sm, fd, fe, fw, me};
   endfunction

   task automatic idle();
      hz.RA1D = 4'd0; hz.RA2D = 4'd0; hz.RA1E = 4'd0; hz.RA2E = 4'd0;
      hz.WA3E = 4'd0; hz.WA3M = 4'd0; hz.WA3W = 4'd0;
      hz.MemtoRegE = 1'b0; hz.RegWriteM = 1'b0; hz.RegWriteW = 1'b0;
      hz.PCWrPendingF = 1'b0; hz.PCSrcW = 1'b0; hz.BranchTakenE = 1'b0;
      hz.MemAccessM = 1'b0; hz.MemReadyM = 1'b0;
   endtask

   // Inputs are already driven; queue expectation, compare mid-cycle, then clock.
   task automatic step(input string tag, input logic [11:0] exp);
      logic [11:0] got;
      logic [11:0] want;
      exp_q.push_back(exp);
      #2;
      got = {hz.ForwardAE, hz.ForwardBE, hz.StallF, hz.StallD, hz.StallE, hz.StallM,
             hz.FlushD, hz.FlushE, hz.FlushW, hz.MemErr};
      want = exp_q.pop_front();
      checks++;
      assert (got === want) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, got, want);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic chk_dbg(input string tag, input state_t st, input logic [4:0] cnt);
      checks++;
      assert ({hz.dbg_state, hz.dbg_cnt} === {st, cnt}) else begin
         errors++;
         $error("FAIL %s observed=%b/%0d expected=%b/%0d", tag, hz.dbg_state, hz.dbg_cnt, st, cnt);
      end
   endtask

   logic [11:0] frz, frz_e, err;

   initial begin
      checks = 0;
      errors = 0;
      frz   = ev(2'b00, 2'b00, 1, 1, 1, 1, 0, 0, 1, 0);
      frz_e = ev(2'b00, 2'b00, 1, 1, 1, 1, 0, 0, 1, 1);
      err   = ev(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1);

      reset = 1'b0;
      idle();
      @(posedge clk);
      @(posedge clk);
      #1;
      chk_dbg("reset_dbg", ST_RUN, 5'd0);
      step("reset_out", 12'd0);
      reset = 1'b1;

      // Forwarding: Memory beats Writeback.
      hz.RegWriteM = 1; hz.WA3M = 4'd3; hz.RegWriteW = 1; hz.WA3W = 4'd3;
      hz.RA1E = 4'd3; hz.RA2E = 4'd3;
      step("fwd_m_prio", ev(2'b10, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0));
      hz.RegWriteM = 0;
      step("fwd_w", ev(2'b01, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0));
      hz.RegWriteM = 1; hz.WA3W = 4'd5; hz.RA1E = 4'd5;
      step("fwd_split", ev(2'b01, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0));
      hz.RA1E = 4'd7; hz.RA2E = 4'd9;
      step("fwd_none", 12'd0);
      idle();

      // Load-use on each source, then the load moves on.
      hz.MemtoRegE = 1; hz.WA3E = 4'd2; hz.RA2D = 4'd2; hz.RA1D = 4'd6;
      step("ldr_ra2", ev(2'b00, 2'b00, 1, 1, 0, 0, 0, 1, 0, 0));
      idle();
      step("ldr_gone", 12'd0);
      hz.MemtoRegE = 1; hz.WA3E = 4'd4; hz.RA1D = 4'd4; hz.RA2D = 4'd1;
      step("ldr_ra1", ev(2'b00, 2'b00, 1, 1, 0, 0, 0, 1, 0, 0));
      hz.BranchTakenE = 1;
      step("ldr_branch", ev(2'b00, 2'b00, 1, 1, 0, 0, 1, 1, 0, 0));
      idle();
      hz.PCWrPendingF = 1;
      step("pc_pending", ev(2'b00, 2'b00, 1, 0, 0, 0, 1, 0, 0, 0));
      idle(); hz.PCSrcW = 1;
      step("pcsrcw", ev(2'b00, 2'b00, 0, 0, 0, 0, 1, 0, 0, 0));
      idle();

      // Memory wait acknowledged on the 4th cycle.
      hz.MemAccessM = 1;
      step("mw_frz1", frz);
      chk_dbg("mw_dbg", ST_WAIT, 5'd1);
      step("mw_frz2", frz);
      step("mw_frz3", frz);
      hz.MemReadyM = 1;
      step("mw_release", 12'd0);
      idle();
      chk_dbg("mw_run", ST_RUN, 5'd0);
      step("mw_idle", 12'd0);

      // Branch while frozen is deferred to the release cycle.
      hz.MemAccessM = 1;
      step("br_frz1", frz);
      hz.BranchTakenE = 1;
      step("br_frz2", frz);
      hz.MemReadyM = 1;
      step("br_release", ev(2'b00, 2'b00, 0, 0, 0, 0, 1, 1, 0, 0));
      idle();

      // Timeout: 16 frozen cycles, release on the 17th, sticky error.
      hz.MemAccessM = 1;
      for (int i = 0; i < 16; i++) step("tmo_frz", frz);
      chk_dbg("tmo_cnt", ST_WAIT, 5'd16);
      step("tmo_release", 12'd0);
      idle();
      for (int i = 0; i < 3; i++) step("tmo_sticky", err);
      hz.MemtoRegE = 1; hz.WA3E = 4'd8; hz.RA1D = 4'd8;
      step("tmo_sticky_ldr", ev(2'b00, 2'b00, 1, 1, 0, 0, 0, 1, 0, 1));
      idle();

      // Reset during the 2nd wait cycle abandons the access and clears MemErr.
      hz.MemAccessM = 1;
      step("rw_frz1", frz_e);
      reset = 1'b0;
      step("rw_frz2", frz_e);
      reset = 1'b1;
      idle();
      chk_dbg("rw_dbg", ST_RUN, 5'd0);
`ifdef HAZARD_PERF_EN
      checks++;
      assert ({hz.PerfStallCyc, hz.PerfFlushCyc, hz.PerfMemWaitCyc} === 96'd0) else begin
         errors++;
         $error("FAIL rw_perf observed=%0d/%0d/%0d expected=0/0/0",
                hz.PerfStallCyc, hz.PerfFlushCyc, hz.PerfMemWaitCyc);
      end
`endif
      step("rw_idle", 12'd0);
      step("rw_idle2", 12'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
